// File: rtl/placement_readback.sv
// Read-only post-placement checker: walks every node id, fetches its (x,y) from the
// position RAMs, cross-checks the grid RAM and streams one tagged tuple per node.
module placement_readback #(
    parameter int N       = 9,
    parameter int N_NODES = 128,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             rePX,
    output logic [31:0]      addrPX,
    input  logic [31:0]      doutPX,
    output logic             rePY,
    output logic [31:0]      addrPY,
    input  logic [31:0]      doutPY,
    output logic             reGrid,
    output logic [31:0]      addrGrid,
    input  logic [31:0]      doutGrid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_node,
    output logic [31:0]      out_x,
    output logic [31:0]      out_y,
    output logic [2:0]       out_flags,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] n_unplaced,
    output logic [CNT_W-1:0] n_range,
    output logic [CNT_W-1:0] n_mismatch
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_POS    = 3'd1;
    localparam logic [2:0] S_WAIT_POS  = 3'd2;
    localparam logic [2:0] S_CHK       = 3'd3;
    localparam logic [2:0] S_RD_GRID   = 3'd4;
    localparam logic [2:0] S_WAIT_GRID = 3'd5;
    localparam logic [2:0] S_CMP       = 3'd6;
    localparam logic [2:0] S_EMIT      = 3'd7;

    localparam logic [31:0] LAST_NODE = 32'(N_NODES - 1);

    logic [2:0]  state_reg;
    logic [31:0] node_reg, x_reg, y_reg, addr_grid_reg;
    logic [2:0]  flags_reg;
    logic        valid_reg, busy_reg, done_reg;

    logic signed [31:0] px_s, py_s, n_s, grid_addr_s;
    logic               is_unplaced, is_out_of_range, grid_hit;
    logic [2:0]         cnt_inc;
    logic               cnt_clr;
    logic [2:0][CNT_W-1:0] cnt_val;

    // Position data is consumed straight off the RAM outputs in CHK; grid data in CMP.
    assign px_s            = signed'(doutPX);
    assign py_s            = signed'(doutPY);
    assign n_s             = 32'(N);
    assign grid_addr_s     = px_s * n_s + py_s;
    assign is_unplaced     = (px_s == -32'sd1) || (py_s == -32'sd1);
    assign is_out_of_range = (px_s < 0) || (px_s >= n_s) || (py_s < 0) || (py_s >= n_s);
    assign grid_hit        = (doutGrid == node_reg);

    always_comb begin
        cnt_inc = '0;
        if (state_reg == S_CHK) begin
            if (is_unplaced)          cnt_inc[0] = 1'b1;
            else if (is_out_of_range) cnt_inc[1] = 1'b1;
        end
        if (state_reg == S_CMP && !grid_hit) cnt_inc[2] = 1'b1;
    end

    assign cnt_clr = (state_reg == S_IDLE) && start;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] c_reg;
        always_ff @(posedge clk) begin
            if (reset || cnt_clr)
                c_reg <= '0;
            else if (cnt_inc[gi] && (c_reg != {CNT_W{1'b1}}))
                c_reg <= c_reg + 1'b1;
        end
        assign cnt_val[gi] = c_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            node_reg      <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            addr_grid_reg <= '0;
            flags_reg     <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        node_reg  <= '0;
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RD_POS;
                    end
                end
                S_RD_POS:   state_reg <= S_WAIT_POS;
                S_WAIT_POS: state_reg <= S_CHK;
                S_CHK: begin
                    x_reg <= doutPX;
                    y_reg <= doutPY;
                    if (is_unplaced) begin
                        flags_reg <= 3'b001;
                        valid_reg <= 1'b1;
                        state_reg <= S_EMIT;
                    end else if (is_out_of_range) begin
                        flags_reg <= 3'b010;
                        valid_reg <= 1'b1;
                        state_reg <= S_EMIT;
                    end else begin
                        addr_grid_reg <= grid_addr_s;
                        state_reg     <= S_RD_GRID;
                    end
                end
                S_RD_GRID:   state_reg <= S_WAIT_GRID;
                S_WAIT_GRID: state_reg <= S_CMP;
                S_CMP: begin
                    flags_reg <= grid_hit ? 3'b000 : 3'b100;
                    valid_reg <= 1'b1;
                    state_reg <= S_EMIT;
                end
                S_EMIT: begin
                    // Dropping valid here guarantees a gap cycle before the next tuple.
                    if (out_ready) begin
                        valid_reg <= 1'b0;
                        if (node_reg == LAST_NODE) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            node_reg  <= node_reg + 32'd1;
                            state_reg <= S_RD_POS;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign rePX       = (state_reg == S_RD_POS);
    assign rePY       = (state_reg == S_RD_POS);
    assign reGrid     = (state_reg == S_RD_GRID);
    assign addrPX     = node_reg;
    assign addrPY     = node_reg;
    assign addrGrid   = addr_grid_reg;
    assign out_valid  = valid_reg;
    assign out_node   = node_reg;
    assign out_x      = x_reg;
    assign out_y      = y_reg;
    assign out_flags  = flags_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign n_unplaced = cnt_val[0];
    assign n_range    = cnt_val[1];
    assign n_mismatch = cnt_val[2];
endmodule

// File: tb/tb_placement_readback.sv
// Bench for placement_readback: 2-cycle-latency RAM models, a per-node expectation
// table, and directed sequences for backpressure, mid-pass start and mid-pass reset.
module tb_placement_readback;
    localparam int N  = 9;
    localparam int NN = 128;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, out_ready;
    logic          rePX, rePY, reGrid, out_valid, busy, done;
    logic [31:0]   addrPX, addrPY, addrGrid, doutPX, doutPY, doutGrid;
    logic [31:0]   out_node, out_x, out_y;
    logic [2:0]    out_flags;
    logic [CW-1:0] n_unplaced, n_range, n_mismatch;

    placement_readback #(.N(N), .N_NODES(NN), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rePX(rePX), .addrPX(addrPX), .doutPX(doutPX),
        .rePY(rePY), .addrPY(addrPY), .doutPY(doutPY),
        .reGrid(reGrid), .addrGrid(addrGrid), .doutGrid(doutGrid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_node(out_node), .out_x(out_x), .out_y(out_y), .out_flags(out_flags),
        .busy(busy), .done(done),
        .n_unplaced(n_unplaced), .n_range(n_range), .n_mismatch(n_mismatch)
    );

    typedef struct {
        int       x;
        int       y;
        logic [2:0] flags;
    } vec_t;

    vec_t vec[NN];
    int   pos_x[NN];
    int   pos_y[NN];
    int   grid[N*N];

    // RAM models: data appears on the second rising edge after the read pulse.
    logic [31:0] px_s1, py_s1, g_s1;
    always @(posedge clk) begin
        if (rePX) px_s1 <= (addrPX < 32'(NN)) ? pos_x[addrPX[6:0]] : 32'hFFFF_FFFF;
        if (rePY) py_s1 <= (addrPY < 32'(NN)) ? pos_y[addrPY[6:0]] : 32'hFFFF_FFFF;
        if (reGrid) g_s1 <= (addrGrid < 32'(N*N)) ? grid[addrGrid[6:0]] : 32'hFFFF_FFFF;
        doutPX   <= px_s1;
        doutPY   <= py_s1;
        doutGrid <= g_s1;
    end

    // Scoreboard, owned entirely by this process.
    logic clr, kick;
    int   cyc, last_xfer, xfers, gap_err, rd_err, rd_expect;
    int   got_cnt[NN], got_x[NN], got_y[NN], grd_cnt[NN], grd_addr[NN], lat[NN];
    logic [2:0] got_f[NN];
    logic vprev, xprev;

    always @(posedge clk) begin
        if (clr) begin
            xfers = 0; gap_err = 0; rd_err = 0; rd_expect = 0; vprev = 0; xprev = 0;
            for (int i = 0; i < NN; i++) begin
                got_cnt[i] = 0; grd_cnt[i] = 0; grd_addr[i] = -1; lat[i] = -1;
                got_x[i] = 0; got_y[i] = 0; got_f[i] = 3'b111;
            end
        end else begin
            if (kick) last_xfer = cyc;
            if (rePX) begin
                if (!rePY || addrPX != 32'(rd_expect) || addrPY != 32'(rd_expect)) rd_err++;
                rd_expect++;
            end
            if (reGrid && addrPX < 32'(NN)) begin
                grd_cnt[addrPX[6:0]]++;
                grd_addr[addrPX[6:0]] = int'(addrGrid);
            end
            if (xprev && out_valid) gap_err++;
            if (out_valid && !vprev && out_node < 32'(NN)) lat[out_node[6:0]] = cyc - last_xfer;
            xprev = out_valid && out_ready;
            if (out_valid && out_ready) begin
                xfers++;
                last_xfer = cyc;
                if (out_node < 32'(NN)) begin
                    got_cnt[out_node[6:0]]++;
                    got_x[out_node[6:0]] = int'($signed(out_x));
                    got_y[out_node[6:0]] = int'($signed(out_y));
                    got_f[out_node[6:0]] = out_flags;
                end
            end
            vprev = out_valid;
        end
        cyc++;
    end

    int n_vec = 0;
    int n_miss = 0;
    int stall;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    task automatic clear_sb();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic run_pass(input bit inject_start);
        bit finished;
        clear_sb();
        stall = 0;
        finished = 0;
        start = 1'b1; kick = 1'b1;
        @(negedge clk) start = 1'b0; kick = 1'b0;
        for (int k = 0; k < 4000 && !finished; k++) begin
            if (done) begin
                finished = 1;
            end else begin
                if (out_valid && out_node == 32'd4 && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                    chk($sformatf("stall%0d_valid", stall), out_valid, 1);
                    chk($sformatf("stall%0d_data", stall),
                        {out_node[7:0], out_x[7:0], out_y[7:0], 5'd0, out_flags},
                        {8'd4, 8'd1, 8'd1, 5'd0, 3'b100});
                end else begin
                    out_ready = 1'b1;
                end
                start = (inject_start && k == 200);
                @(negedge clk);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("pass_completed", finished, 1);
    endtask

    task automatic check_pass(input string tag);
        for (int i = 0; i < NN; i++) begin
            int  exp_g, exp_a;
            bit  ok;
            exp_g = (vec[i].flags == 3'b000 || vec[i].flags == 3'b100) ? 1 : 0;
            exp_a = exp_g ? vec[i].x * N + vec[i].y : -1;
            ok = got_cnt[i] == 1 && got_x[i] == vec[i].x && got_y[i] == vec[i].y &&
                 got_f[i] == vec[i].flags && grd_cnt[i] == exp_g && grd_addr[i] == exp_a;
            n_vec++;
            if (!ok) begin
                n_miss++;
                $display("FAIL %s node%0d: got n=%0d x=%0d y=%0d f=%b greads=%0d gaddr=%0d, want n=1 x=%0d y=%0d f=%b greads=%0d gaddr=%0d",
                         tag, i, got_cnt[i], got_x[i], got_y[i], got_f[i], grd_cnt[i], grd_addr[i],
                         vec[i].x, vec[i].y, vec[i].flags, exp_g, exp_a);
            end
        end
        chk({tag, "_xfers"}, xfers, NN);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_n_unplaced"}, n_unplaced, 49);
        chk({tag, "_n_range"}, n_range, 2);
        chk({tag, "_n_mismatch"}, n_mismatch, 1);
        chk({tag, "_gap_err"}, gap_err, 0);
        chk({tag, "_read_seq_err"}, rd_err, 0);
        chk({tag, "_stall_cycles"}, stall, 5);
        chk({tag, "_lat_node0"}, lat[0], 7);
        chk({tag, "_lat_node1"}, lat[1], 7);
        chk({tag, "_lat_node5"}, lat[5], 4);
        chk({tag, "_lat_node8"}, lat[8], 4);
    endtask

    initial begin
        // Node i < 81 sits in cell (i+21)%81 so node 0 lands at (2,3); the rest are unplaced.
        for (int c = 0; c < N*N; c++) grid[c] = -1;
        for (int i = 0; i < NN; i++) begin
            pos_x[i] = -1; pos_y[i] = -1;
            vec[i] = '{-1, -1, 3'b001};
        end
        for (int i = 0; i < N*N; i++) begin
            int c;
            c = (i + 21) % (N*N);
            pos_x[i] = c / N; pos_y[i] = c % N; grid[c] = i;
            vec[i] = '{c / N, c % N, 3'b000};
        end
        pos_x[70] = -1; pos_y[70] = -1; vec[70] = '{-1, -1, 3'b001};
        pos_x[4]  = 1;  pos_y[4]  = 1;  vec[4]  = '{1, 1, 3'b100};
        grid[10]  = 6;
        pos_x[5]  = -1; pos_y[5]  = -1; vec[5]  = '{-1, -1, 3'b001};
        pos_x[7]  = 9;  pos_y[7]  = 0;  vec[7]  = '{9, 0, 3'b010};
        pos_x[8]  = 0;  pos_y[8]  = -2; vec[8]  = '{0, -2, 3'b010};

        cyc = 0; last_xfer = 0; clr = 1'b1; kick = 1'b0;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0; clr = 1'b0;
        @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_busy_done", {busy, done}, 0);
        chk("reset_counters", {n_unplaced, n_range, n_mismatch}, 0);
        chk("reset_read_enables", {rePX, rePY, reGrid}, 0);

        run_pass(1'b1);
        check_pass("pass1");

        // Abandon a pass while the first grid read is in flight.
        clear_sb();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 50 && !seen; k++) begin
                if (reGrid) seen = 1;
                else @(negedge clk);
            end
            chk("abort_grid_read_seen", seen, 1);
        end
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("abort_strobes", {out_valid, busy, done, rePX, rePY, reGrid}, 0);
        chk("abort_addrs", {addrPX, addrPY, addrGrid}, 0);
        chk("abort_tuple", {out_node, out_x, out_y, out_flags}, 0);
        chk("abort_counters", {n_unplaced, n_range, n_mismatch}, 0);
        chk("abort_no_tuple", xfers, 0);
        reset = 1'b0;
        @(negedge clk);

        run_pass(1'b0);
        check_pass("pass2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
